// File: rtl/nios_setup_v2_switch_pkg.sv
// Shared definitions for the switch edge controller: register offsets,
// edge-mode encodings and the per-bit debounce state.
package nios_setup_v2_switch_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2,
    EDGE_OFF  = 2'd3
  } edge_mode_e;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/nios_setup_v2_switch_edge_ctrl_if.sv
// Avalon-MM register port of the switch edge controller.
// Write: accepted on the clk edge where chipselect=1 and write_n=0, no wait states.
// Read: readdata is registered from address every clk (chipselect ignored), 1-cycle latency.
interface nios_setup_v2_switch_edge_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_setup_v2_switch_debounce.sv
// One switch bit: 2-flop synchronizer, then a stable/pending debounce FSM whose
// counter must see DEBOUNCE_CYCLES consecutive differing cycles before accepting a level.
module nios_setup_v2_switch_debounce
  import nios_setup_v2_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      in_raw,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output db_state_e state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign differ = sync2_q ^ level_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (!differ) begin
          cnt_d = '0;
        end else if (DEBOUNCE_CYCLES == 1) begin
          accept = 1'b1;
        end else begin
          state_d = DB_PENDING;
          cnt_d   = CW'(1);
        end
      end
      DB_PENDING: begin
        // A single agreeing cycle rejects the whole pending change as a glitch.
        if (!differ) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      level_d = sync2_q;
      state_d = DB_STABLE;
      cnt_d   = '0;
    end
  end

  assign level = level_q;
  assign rise  = accept & sync2_q;
  assign fall  = accept & ~sync2_q;
  assign state = state_q;

endmodule

// File: rtl/nios_setup_v2_switch_edge_ctrl.sv
// Avalon-MM switch conditioner: per-bit debounce, edge capture with W1C,
// per-bit interrupt mask and a registered level interrupt.
module nios_setup_v2_switch_edge_ctrl
  import nios_setup_v2_switch_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_setup_v2_switch_edge_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq,
  output logic [WIDTH-1:0]      dbg_pending
);

  logic [WIDTH-1:0] level, rise, fall;
  db_state_e        db_state [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_setup_v2_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .in_raw (in_port[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .state  (db_state[i])
    );
    assign dbg_pending[i] = (db_state[i] == DB_PENDING);
  end

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  edge_mode_e       ctrl_q, ctrl_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_set;
  logic             wr;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      ctrl_q     <= EDGE_RISE;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (ctrl_q)
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      EDGE_BOTH: edge_set = rise | fall;
      default:   edge_set = '0;
    endcase

    irqmask_d = irqmask_q;
    ctrl_d    = ctrl_q;
    edgecap_d = edgecap_q;
    if (wr && bus.address == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == ADDR_CTRL)    ctrl_d = edge_mode_e'(bus.writedata[1:0]);
    if (wr && bus.address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~bus.writedata[WIDTH-1:0];
    // OR-ing the new events last lets a capture win over a same-cycle clear.
    edgecap_d = edgecap_d | edge_set;

    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = level;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d[1:0]       = ctrl_q;
    endcase

    irq_d = |(edgecap_q & irqmask_q);
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_nios_setup_v2_switch_edge_ctrl.sv
// Bench for the switch edge controller: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model of the switch rules.
module tb_nios_setup_v2_switch_edge_ctrl;

  localparam int W = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq;
  logic [W-1:0] dbg_pending;

  nios_setup_v2_switch_edge_ctrl_if bus ();

  nios_setup_v2_switch_edge_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .in_port    (in_port),
    .irq        (irq),
    .dbg_pending(dbg_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_deb, m_mask, m_edge;
  logic [1:0]   m_ctrl;
  logic         m_irq;
  int           m_run [W];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_edge = '0;
    m_ctrl = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  function automatic bit accept_next(input int i);
    return (m_s2[i] != m_deb[i]) && (m_run[i] + 1 == N);
  endfunction

  // Advance one clock: update the model from the inputs present at the edge, then compare.
  task automatic tick();
    logic         wr;
    logic [W-1:0] rise, fall, set, w1c;
    logic [31:0]  rd;
    logic         irq_n;
    @(posedge clk);
    wr = bus.chipselect && !bus.write_n;
    rd = '0;
    case (bus.address)
      2'd0: rd[W-1:0] = m_deb;
      2'd1: rd[W-1:0] = m_mask;
      2'd2: rd[W-1:0] = m_edge;
      default: rd[1:0] = m_ctrl;
    endcase
    irq_n = |(m_edge & m_mask);
    rise = '0; fall = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] != m_deb[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == N) begin
        m_deb[i] = m_s2[i];
        rise[i]  = m_s2[i];
        fall[i]  = !m_s2[i];
        m_run[i] = 0;
      end
    end
    set = ((m_ctrl == 2'd0 || m_ctrl == 2'd2) ? rise : '0) |
          ((m_ctrl == 2'd1 || m_ctrl == 2'd2) ? fall : '0);
    w1c = (wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
    m_edge = (m_edge & ~w1c) | set;
    if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
    if (wr && bus.address == 2'd3) m_ctrl = bus.writedata[1:0];
    m_s2 = m_s1;
    m_s1 = in_port;
    m_irq = irq_n;
    exp_q.push_back(rd);
    #1;
    check_eq("readdata", bus.readdata, exp_q.pop_front());
    check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic bus_idle(input logic [1:0] addr);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = addr;
    bus.writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus_idle(addr);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic read_reg(input logic [1:0] addr, input string tag, input logic [31:0] exp);
    bus_idle(addr);
    tick();
    check_eq(tag, bus.readdata, exp);
  endtask

  initial begin
    bus_idle(2'd0);
    model_reset();
    #1;
    check_eq("rst_readdata", bus.readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // all offsets read zero after reset
    for (int a = 0; a < 4; a++) read_reg(2'(a), "rst_reg", 32'd0);

    // bit0 goes high: debounced after 2 sync + N cycles, captured as a rising edge
    in_port = 2'b01;
    ticks(8);
    read_reg(2'd0, "data_01", 32'd1);
    read_reg(2'd2, "edgecap_01", 32'd1);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);

    bus_write(2'd1, 32'd1);
    tick();
    check_eq("irq_unmask", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'd1);
    tick();
    check_eq("irq_w1c", {31'd0, irq}, 32'd0);

    // 3-cycle glitch on bit1 is rejected
    in_port = 2'b11;
    ticks(3);
    in_port = 2'b01;
    ticks(10);
    read_reg(2'd0, "glitch_data", 32'd1);
    read_reg(2'd2, "glitch_edgecap", 32'd0);

    // 4-cycle pulse on bit1 under each capture mode
    bus_write(2'd3, 32'd2);
    in_port = 2'b11; ticks(4); in_port = 2'b01; ticks(12);
    read_reg(2'd2, "both_edgecap", 32'd2);
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd1);
    in_port = 2'b11; ticks(6);
    read_reg(2'd2, "fall_no_rise", 32'd0);
    in_port = 2'b01; ticks(10);
    read_reg(2'd2, "fall_edgecap", 32'd2);
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd3);
    in_port = 2'b11; ticks(4); in_port = 2'b01; ticks(12);
    read_reg(2'd2, "off_edgecap", 32'd0);

    // rising capture on bit1 in the same cycle as its W1C: capture wins
    bus_write(2'd3, 32'd0);
    bus_write(2'd1, 32'd3);
    in_port = 2'b11;
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
        if (accept_next(1)) begin
          hit = 1'b1;
          bus_write(2'd2, 32'd2);
        end else begin
          tick();
        end
      end
      check_eq("coincide_seen", {31'd0, hit}, 32'd1);
    end
    ticks(2);
    read_reg(2'd2, "coincide_edgecap", 32'd2);
    check_eq("coincide_irq", {31'd0, irq}, 32'd1);

    // asynchronous reset while both bits are pending a fall
    in_port = 2'b00;
    ticks(4);
    check_eq("pending_before_rst", {30'd0, dbg_pending}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check_eq("arst_readdata", bus.readdata, 32'd0);
    check_eq("arst_irq", {31'd0, irq}, 32'd0);
    check_eq("arst_pending", {30'd0, dbg_pending}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus_idle(2'd2);
    ticks(12);
    read_reg(2'd2, "post_rst_edgecap", 32'd0);
    read_reg(2'd0, "post_rst_data", 32'd0);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) in_port = W'($urandom_range(0, (1 << W) - 1));
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus_idle(2'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
